instr_fetch_queue: RTL and testbench

Instruction fetch front end for the single-cycle MIPS core. It issues word reads to instruction memory over a req/ack handshake and buffers returned words, each with its PC, in a small FIFO. It presents them to the decode/controller stage over a valid/ready interface. A redirect input flushes the buffer and restarts fetch at a new PC; the core raises it on a taken branch or jump.

---
 rtl/instr_fetch_queue.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues word reads to instruction memory over a
// req/ack handshake, buffers returned {pc, word} pairs in a small FIFO and
// presents the head to decode over valid/ready. A redirect flushes the FIFO
// and restarts fetch at a new PC; a request already in flight is drained
// (DROP state) because the memory handshake cannot be withdrawn.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned    PTR_W = $clog2(DEPTH);
    localparam int unsigned    CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DROP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_nxt;
    logic [31:0]      r_addr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [31:0]      r_mem_pc   [DEPTH];
    logic [31:0]      r_mem_word [DEPTH];
    logic             w_push;
    logic             w_pop;

    // A response is kept only in REQ and only if no redirect flushes it.
    assign w_push     = (r_state == ST_REQ) && imem_ack && !redirect;
    assign w_pop      = inst_valid && inst_ready && !redirect;
    assign inst_valid = (r_count != '0);
    assign imem_req   = (r_state != ST_IDLE);
    assign imem_addr  = r_addr;

    // Head is read straight from storage; forced to zero when empty.
    assign inst    = inst_valid ? r_mem_word[r_rd_ptr] : '0;
    assign inst_pc = inst_valid ? r_mem_pc[r_rd_ptr]   : '0;

    // Occupancy after this cycle's push/pop; a redirect empties the FIFO.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_count_nxt = r_count;
        if (redirect) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Next fetch PC: redirect target (word aligned) wins over sequential advance.
    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        if (redirect) begin
            w_fetch_pc_nxt = redirect_pc & ~32'h0000_0003;
        end else if ((r_state == ST_REQ) && imem_ack) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
    end

    // Next-state logic for the request FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (redirect || (r_count < FULL) || w_pop) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    w_state_nxt = imem_ack ? ST_REQ : ST_DROP;
                end else if (imem_ack) begin
                    w_state_nxt = (w_count_nxt < FULL) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, fetch PC and request address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            // While draining a stale request the address must stay on the old PC.
            if (w_state_nxt != ST_DROP) begin
                r_addr <= w_fetch_pc_nxt;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; outputs are gated by count so stale entries are never visible.
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
            r_mem_word[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue. A bench-side memory answers requests
// with addr ^ 32'hA5A5_A5A5; accepted responses are pushed to a scoreboard
// and compared against the FIFO head whenever it is popped.
module tb_instr_fetch_queue;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        hi_imem_req;
    logic [31:0] hi_imem_addr;
    logic        hi_inst_valid;
    logic [31:0] hi_inst;
    logic [31:0] hi_inst_pc;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard of expected {pc, word} and bench-side fetch model.
    logic [63:0] sb [$];
    logic [31:0] exp_fetch = 32'h0;
    logic [31:0] drop_addr = 32'h0;
    bit          dropping  = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (hi_imem_req),
        .imem_addr  (hi_imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (hi_inst_valid),
        .inst       (hi_inst),
        .inst_pc    (hi_inst_pc),
        .inst_ready (inst_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered just after a falling edge. Checks the head and
    // request address, drives inputs, updates the model, then advances.
    task automatic tick(input bit ack_en, input bit ready, input bit redir, input logic [31:0] rpc);
        logic [63:0] e;
        if (!inst_valid) begin
            check("empty_inst", inst, 32'h0);
            check("empty_pc", inst_pc, 32'h0);
        end
        if (imem_req) begin
            check("req_addr", imem_addr, dropping ? drop_addr : exp_fetch);
        end
        imem_ack    = ack_en && imem_req;
        imem_rdata  = imem_addr ^ K;
        inst_ready  = ready;
        redirect    = redir;
        redirect_pc = rpc;
        if (inst_valid && ready && !redir) begin
            check("pop_expected", 32'(sb.size() != 0), 32'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pop_pc", inst_pc, e[63:32]);
                check("pop_inst", inst, e[31:0]);
            end
        end
        if (imem_ack) begin
            if (dropping) begin
                dropping = 1'b0;
            end else if (!redir) begin
                sb.push_back({imem_addr, imem_rdata});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        if (redir) begin
            sb.delete();
            if (imem_req && !imem_ack && !dropping) begin
                dropping  = 1'b1;
                drop_addr = imem_addr;
            end
            exp_fetch = rpc & ~32'h0000_0003;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] old_addr;
        logic [31:0] hi_pcs [3];
        int          k;

        imem_ack    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        rst         = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", inst_pc, 32'h0);

        // Streaming: ack tied high, consumer always ready.
        @(negedge clk);
        rst = 1'b1;
        tick(1, 1, 0, 0);
        check("first_req", 32'(imem_req), 32'h1);
        check("first_valid_early", 32'(inst_valid), 32'h0);
        tick(1, 1, 0, 0);
        check("first_valid", 32'(inst_valid), 32'h1);
        check("first_pc", inst_pc, 32'h0);
        for (int i = 0; i < 8; i++) begin
            check("stream_valid", 32'(inst_valid), 32'h1);
            tick(1, 1, 0, 0);
        end

        // Fill to DEPTH with consumer stalled, then drain in order.
        tick(1, 0, 1, 32'h0);
        check("fill_flushed", 32'(inst_valid), 32'h0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("full_no_req", 32'(imem_req), 32'h0);
            check("full_head_pc", inst_pc, 32'h0);
            tick(1, 0, 0, 0);
        end
        for (int i = 0; i < 6; i++) begin
            check("resume_valid", 32'(inst_valid), 32'h1);
            tick(1, 1, 0, 0);
        end

        // Redirect with two entries buffered.
        k = 0;
        while (inst_valid && k < 8) begin
            tick(0, 1, 0, 0);
            k++;
        end
        check("drained", 32'(inst_valid), 32'h0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("two_buffered", 32'(inst_valid), 32'h1);
        tick(1, 0, 1, 32'h0000_0103);
        check("redir_valid_drop", 32'(inst_valid), 32'h0);
        check("redir_req", 32'(imem_req), 32'h1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        tick(1, 1, 0, 0);
        check("redir_first_valid", 32'(inst_valid), 32'h1);
        check("redir_first_pc", inst_pc, 32'h0000_0100);
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);

        // Redirect while a request is outstanding and ack is withheld.
        old_addr = imem_addr;
        tick(0, 1, 1, 32'h0000_0200);
        for (int i = 0; i < 3; i++) begin
            check("drop_req", 32'(imem_req), 32'h1);
            check("drop_addr_held", imem_addr, old_addr);
            check("drop_valid", 32'(inst_valid), 32'h0);
            tick(0, 1, 0, 0);
        end
        tick(1, 1, 0, 0);
        check("after_drop_addr", imem_addr, 32'h0000_0200);
        check("after_drop_valid", 32'(inst_valid), 32'h0);
        tick(1, 1, 0, 0);
        check("after_drop_first_pc", inst_pc, 32'h0000_0200);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);

        // Redirect with FIFO full, ack high and consumer ready.
        for (int i = 0; i < 6; i++) tick(1, 0, 0, 0);
        check("full2_no_req", 32'(imem_req), 32'h0);
        check("full2_valid", 32'(inst_valid), 32'h1);
        tick(1, 1, 1, 32'h0000_0400);
        check("full_redir_valid", 32'(inst_valid), 32'h0);
        check("full_redir_req", 32'(imem_req), 32'h1);
        check("full_redir_addr", imem_addr, 32'h0000_0400);
        tick(1, 1, 0, 0);
        check("full_redir_first_pc", inst_pc, 32'h0000_0400);
        tick(1, 1, 0, 0);

        // PC wrap from a high reset PC, then asynchronous reset mid-request.
        imem_ack   = 1'b0;
        redirect   = 1'b0;
        inst_ready = 1'b1;
        rst        = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        check("hi_req", 32'(hi_imem_req), 32'h1);
        check("hi_addr", hi_imem_addr, 32'hFFFF_FFF8);
        imem_rdata = hi_imem_addr ^ K;
        hi_pcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hi_valid", 32'(hi_inst_valid), 32'h1);
            check("hi_pc", hi_inst_pc, hi_pcs[i]);
            check("hi_inst", hi_inst, hi_pcs[i] ^ K);
            imem_rdata = hi_imem_addr ^ K;
        end
        #2;
        check("hi_req_before_rst", 32'(hi_imem_req), 32'h1);
        rst = 1'b0;
        #1;
        check("async_req", 32'(hi_imem_req), 32'h0);
        check("async_addr", hi_imem_addr, 32'hFFFF_FFF8);
        check("async_valid", 32'(hi_inst_valid), 32'h0);
        check("async_inst", hi_inst, 32'h0);
        check("async_pc", hi_inst_pc, 32'h0);
        check("async_lo_addr", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
